mem_req_replay: RTL
===================

// Module: mem_req_replay
// PURPOSE
//  Sits between an accelerator's mem_req/mem_resp port and the L1 data-cache port.
//  Stamps each request with a unique tag and tracks one outstanding request.
//  Re-issues nacked requests after a back-off; forwards only the matching, non-nacked
//  response upstream, so the accelerator ctrl FSM sees exactly one mem_back per request.
// PARAMETERS
//  MAX_RETRY    4    nacks tolerated per request; the next nack is forwarded with acc_err=1
//  BACKOFF_CYC  3    idle cycles between a nack and the re-issue (>=1)
//  TIMEOUT_CYC  256  WAIT cycles before forced re-issue (only with MEM_REPLAY_TIMEOUT_EN)
// PORTS
//  clk          in   1    clock
//  rst          in   1    synchronous, active-high reset
//  acc_req_vld  in   1    accelerator request valid
//  acc_req_rdy  out  1    block accepts a request (IDLE only)
//  acc_req      in   124  {addr[123:84],tag[83:74],cmd[73:69],typ[68:66],kill[65],phys[64],data[63:0]}
//  mem_req_vld  out  1    request to cache valid
//  mem_req_rdy  in   1    cache accepts request
//  mem_req      out  124  latched acc_req with tag field replaced by tag_q
//  mem_resp_vld in   1    cache response valid (no backpressure)
//  mem_resp     in   253  tag[212:203], nack[130], remaining fields opaque
//  acc_resp_vld out  1    one-cycle pulse: final response for current request
//  acc_resp     out  253  registered copy of the accepted mem_resp
//  acc_err      out  1    qualifies acc_resp_vld: retry limit exceeded
//  busy         out  1    state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, tag_q=0, retry_q=0, every output 0 (acc_req_rdy=1 from the first cycle after reset).
//  - States IDLE, ISSUE, WAIT, BACKOFF, DONE.
//  - IDLE: acc_req_rdy=1. On acc_req_vld: latch acc_req, set retry_q=0, go ISSUE.
//  - ISSUE: mem_req_vld=1, held stable until mem_req_rdy. On handshake go WAIT.
//  - WAIT, mem_resp_vld with resp tag==tag_q:
//      nack=0: capture resp, go DONE.
//      nack=1 and retry_q<MAX_RETRY: retry_q++, load timer with BACKOFF_CYC, go BACKOFF.
//      nack=1 and retry_q==MAX_RETRY: capture resp, set err, go DONE.
//  - WAIT, tag mismatch: drop the response and stay in WAIT. A response arriving in any
//    state other than WAIT is always dropped.
//  - BACKOFF: timer decrements each cycle; at 0 go ISSUE. The same tag is reused.
//  - DONE (one cycle): acc_resp_vld=1, acc_err=err. tag_q++ (10-bit, wraps 1023->0), then go IDLE.
//  - Latency (no nack, rdy high): accept at cycle 0, mem_req_vld at 1, response at N,
//    acc_resp_vld at N+1.
//  - Back-to-back: the next acc_req is accepted no earlier than the cycle after DONE.
//  - Reset in any state aborts the request. The tag restarts at 0; a late response carrying
//    the old tag is dropped unless it matches a new request.
// CONFIGURATION
//  MEM_REPLAY_TIMEOUT_EN defined:
//    - a WAIT-cycle counter runs; at TIMEOUT_CYC with no matching response, go ISSUE;
//    - this consumes a retry under the same MAX_RETRY limit;
//    - at the limit, go DONE with acc_err=1 and acc_resp=0.
//  MEM_REPLAY_TIMEOUT_EN undefined: WAIT has no exit except a matching response.
//    The timeout counter is not built.
// STRUCTURE
//  - Package mem_if_pkg: field offsets and widths for mem_req/mem_resp (addr, tag, cmd,
//    typ, nack), M_XRD=5'd0, M_XWR=5'd1, and the state encoding.
//  - Sub-module mem_replay_timer: loadable down-counter with a zero flag. It is shared by
//    BACKOFF and, when enabled, the timeout.
//  - FSM and datapath registers stay in the top module.
// TESTING
//  1. Store addr=0x100 data=0xDEAD, rdy=1, resp tag=0 nack=0 at +2
//     -> mem_req tag=0; acc_resp_vld pulses once at +3; next tag=1.
//  2. Load, first response nack=1 -> mem_req_vld low 3 cycles, re-issued with the same tag;
//     the second response (nack=0) is forwarded; acc_err=0.
//  3. MAX_RETRY=4, five consecutive nacks -> 5 issues total, acc_resp_vld with acc_err=1.
//  4. Response tag=7 while tag_q=3 in WAIT -> dropped, no acc_resp_vld, still busy.
//     Tag=3 follows -> forwarded.
//  5. rst asserted in WAIT -> next cycle IDLE, all outputs 0, acc_req_rdy=1.
//     A late response is ignored.
//  6. Run 1025 requests -> request 1024 carries tag 0.
//     With TIMEOUT_EN and TIMEOUT_CYC=8 and no response -> re-issue after 8 WAIT cycles.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Field layout, opcodes and FSM encoding shared by the mem_req_replay slice.
package mem_if_pkg;

    localparam int unsigned REQ_W  = 124;
    localparam int unsigned RESP_W = 253;
    localparam int unsigned ADDR_W = 40;
    localparam int unsigned TAG_W  = 10;
    localparam int unsigned CMD_W  = 5;
    localparam int unsigned TYP_W  = 3;
    localparam int unsigned DATA_W = 64;

    localparam int unsigned REQ_ADDR_LSB  = 84;
    localparam int unsigned REQ_TAG_LSB   = 74;
    localparam int unsigned REQ_CMD_LSB   = 69;
    localparam int unsigned REQ_TYP_LSB   = 66;
    localparam int unsigned RESP_TAG_LSB  = 203;
    localparam int unsigned RESP_NACK_BIT = 130;

    localparam logic [CMD_W-1:0] M_XRD = 5'd0;
    localparam logic [CMD_W-1:0] M_XWR = 5'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_BACKOFF,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
        logic [CMD_W-1:0]  cmd;
        logic [TYP_W-1:0]  typ;
        logic              kill;
        logic              phys;
        logic [DATA_W-1:0] data;
    } mem_req_t;

endpackage

// File: rtl/mem_replay_timer.sv
// Loadable down-counter with a zero flag; shared by back-off and WAIT timeout.
module mem_replay_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/mem_req_replay.sv
// Tags accelerator requests, replays nacked ones after a back-off and forwards one response each.
// Optional WAIT timeout with forced re-issue: define MEM_REPLAY_TIMEOUT_EN.
module mem_req_replay
    import mem_if_pkg::*;
#(
    parameter int unsigned MAX_RETRY   = 4,
    parameter int unsigned BACKOFF_CYC = 3
`ifdef MEM_REPLAY_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 256
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_req_vld,
    output logic              acc_req_rdy,
    input  logic [REQ_W-1:0]  acc_req,
    output logic              mem_req_vld,
    input  logic              mem_req_rdy,
    output logic [REQ_W-1:0]  mem_req,
    input  logic              mem_resp_vld,
    input  logic [RESP_W-1:0] mem_resp,
    output logic              acc_resp_vld,
    output logic [RESP_W-1:0] acc_resp,
    output logic              acc_err,
    output logic              busy
);

    localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
`ifdef MEM_REPLAY_TIMEOUT_EN
    localparam int unsigned TMR_MAX = (TIMEOUT_CYC > BACKOFF_CYC) ? TIMEOUT_CYC : BACKOFF_CYC;
`else
    localparam int unsigned TMR_MAX = BACKOFF_CYC;
`endif
    localparam int unsigned TMR_W = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);

    state_e              state_q, state_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                err_q, err_d;
    mem_req_t            mreq_q, mreq_d;
    logic [RESP_W-1:0]   resp_q, resp_d;

    logic                rdy_q, mreq_vld_q, resp_vld_q, acc_err_q, busy_q;

    logic                tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0]    tmr_val;
    logic                resp_match, resp_nack, retry_left;

    assign resp_match = mem_resp_vld && (mem_resp[RESP_TAG_LSB +: TAG_W] == tag_q);
    assign resp_nack  = mem_resp[RESP_NACK_BIT];
    assign retry_left = (retry_q < RETRY_W'(MAX_RETRY));

    mem_replay_timer #(.CNT_W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero_c   (tmr_zero)
    );

    // Timers load N-1 so the zero flag is seen on the N-th cycle of the state.
    always_comb begin
        state_d  = state_q;
        tag_d    = tag_q;
        retry_d  = retry_q;
        err_d    = err_q;
        mreq_d   = mreq_q;
        resp_d   = resp_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (acc_req_vld) begin
                    mreq_d     = mem_req_t'(acc_req);
                    mreq_d.tag = tag_q;
                    retry_d    = '0;
                    err_d      = 1'b0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_req_rdy) begin
                    state_d = ST_WAIT;
`ifdef MEM_REPLAY_TIMEOUT_EN
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(TIMEOUT_CYC - 1);
`endif
                end
            end
            ST_WAIT: begin
                if (resp_match) begin
                    if (!resp_nack) begin
                        resp_d  = mem_resp;
                        state_d = ST_DONE;
                    end else if (retry_left) begin
                        retry_d  = retry_q + RETRY_W'(1);
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(BACKOFF_CYC - 1);
                        state_d  = ST_BACKOFF;
                    end else begin
                        resp_d  = mem_resp;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
`ifdef MEM_REPLAY_TIMEOUT_EN
                else if (tmr_zero) begin
                    if (retry_left) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_ISSUE;
                    end else begin
                        resp_d  = '0;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
`endif
            end
            ST_BACKOFF: begin
                if (tmr_zero) begin
                    state_d = ST_ISSUE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_DONE: begin
                tag_d   = tag_q + TAG_W'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tag_q      <= '0;
            retry_q    <= '0;
            err_q      <= 1'b0;
            mreq_q     <= '0;
            resp_q     <= '0;
            rdy_q      <= 1'b1;
            mreq_vld_q <= 1'b0;
            resp_vld_q <= 1'b0;
            acc_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            retry_q    <= retry_d;
            err_q      <= err_d;
            mreq_q     <= mreq_d;
            resp_q     <= resp_d;
            rdy_q      <= (state_d == ST_IDLE);
            mreq_vld_q <= (state_d == ST_ISSUE);
            resp_vld_q <= (state_d == ST_DONE);
            acc_err_q  <= (state_d == ST_DONE) && err_d;
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign acc_req_rdy  = rdy_q;
    assign mem_req_vld  = mreq_vld_q;
    assign mem_req      = mreq_q;
    assign acc_resp_vld = resp_vld_q;
    assign acc_resp     = resp_q;
    assign acc_err      = acc_err_q;
    assign busy         = busy_q;

endmodule
